uart_rx_deframer: RTL and testbench

//  Serial receive front end feeding the UART core's receive path: synchronises
//  the RX pin, detects the start bit and samples 8N1/8E1/8O1 frames at 16x oversampling.

---
 rtl/uart_rx_deframer_if.sv | 30 +++
 rtl/uart_rx_deframer.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deframer_if.sv
// Holding-register side of the UART receive deframer: received byte, status flags and pop.
// The deframer drives the byte and flags; the APB slave pops with rd_uart.
interface uart_rx_deframer_if #(
    parameter int DBIT = 8
);
    logic            rd_uart;
    logic [DBIT-1:0] dout;
    logic            rx_ready;
    logic            parity_err;
    logic            framing_err;
    logic            overflow;

    modport master (
        input  rd_uart,
        output dout,
        output rx_ready,
        output parity_err,
        output framing_err,
        output overflow
    );

    modport slave (
        output rd_uart,
        input  dout,
        input  rx_ready,
        input  parity_err,
        input  framing_err,
        input  overflow
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive front end: synchronises rx, samples 8N1/8E1/8O1 frames at OVS x oversampling
// and hands each byte to a one-entry holding register with ready/overflow/parity/framing flags.
module uart_rx_deframer #(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic s_tick,
    input  logic rx,
    input  logic parity_en,
    input  logic parity_odd,
    uart_rx_deframer_if.master hold
);

    // s_cnt must reach both the bit period and the stop-bit length
    localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] START_LAST = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] BIT_LAST   = SW'(OVS - 1);
    localparam logic [SW-1:0] STOP_LAST  = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic            rx_meta;
    logic            rx_s;
    state_t          state, state_n;
    logic [SW-1:0]   s_cnt, s_cnt_n;
    logic [NW-1:0]   n_cnt, n_cnt_n;
    logic [DBIT-1:0] shreg, shreg_n;
    logic            accum, accum_n;
    logic            par_en_q, par_en_n;
    logic            par_odd_q, par_odd_n;
    logic            perr_q, perr_n;
    logic            frame_done;
    logic            ferr_now;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s_cnt     <= '0;
            n_cnt     <= '0;
            shreg     <= '0;
            accum     <= 1'b0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state     <= state_n;
            s_cnt     <= s_cnt_n;
            n_cnt     <= n_cnt_n;
            shreg     <= shreg_n;
            accum     <= accum_n;
            par_en_q  <= par_en_n;
            par_odd_q <= par_odd_n;
            perr_q    <= perr_n;
        end
    end

    // Each sampling state waits for its last tick, otherwise just advances s_cnt on s_tick
    always_comb begin
        state_n    = state;
        s_cnt_n    = s_cnt;
        n_cnt_n    = n_cnt;
        shreg_n    = shreg;
        accum_n    = accum;
        par_en_n   = par_en_q;
        par_odd_n  = par_odd_q;
        perr_n     = perr_q;
        frame_done = 1'b0;
        ferr_now   = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n   = START;
                    s_cnt_n   = '0;
                    par_en_n  = parity_en;
                    par_odd_n = parity_odd;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt == START_LAST) begin
                        s_cnt_n = '0;
                        if (!rx_s) begin
                            state_n = DATA;
                            n_cnt_n = '0;
                            accum_n = 1'b0;
                            perr_n  = 1'b0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_cnt_n = s_cnt + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt == BIT_LAST) begin
                        s_cnt_n = '0;
                        shreg_n = {rx_s, shreg[DBIT-1:1]};
                        accum_n = accum ^ rx_s;
                        if (n_cnt == N_LAST) begin
                            state_n = par_en_q ? PARITY : STOP;
                        end else begin
                            n_cnt_n = n_cnt + NW'(1);
                        end
                    end else begin
                        s_cnt_n = s_cnt + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt == BIT_LAST) begin
                        s_cnt_n = '0;
                        perr_n  = accum ^ rx_s ^ par_odd_q;
                        state_n = STOP;
                    end else begin
                        s_cnt_n = s_cnt + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt == STOP_LAST) begin
                        s_cnt_n    = '0;
                        ferr_now   = ~rx_s;
                        frame_done = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        s_cnt_n = s_cnt + SW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                s_cnt_n = '0;
            end
        endcase
    end

    // A finished frame is loaded if the register is free or being popped this cycle, else dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            hold.dout        <= '0;
            hold.rx_ready    <= 1'b0;
            hold.parity_err  <= 1'b0;
            hold.framing_err <= 1'b0;
            hold.overflow    <= 1'b0;
        end else if (frame_done) begin
            if (!hold.rx_ready || hold.rd_uart) begin
                hold.dout        <= shreg;
                hold.parity_err  <= perr_q;
                hold.framing_err <= ferr_now;
                hold.rx_ready    <= 1'b1;
                hold.overflow    <= 1'b0;
            end else begin
                hold.overflow <= 1'b1;
            end
        end else if (hold.rd_uart && hold.rx_ready) begin
            hold.rx_ready <= 1'b0;
            hold.overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: 16x oversampling with s_tick every 4 clk,
// frames driven bit by bit on rx with hand-computed expected register contents.
module tb_uart_rx_deframer;

    localparam int BIT_CLKS = 64;

    logic clk        = 1'b0;
    logic reset      = 1'b1;
    logic s_tick     = 1'b0;
    logic rx         = 1'b1;
    logic parity_en  = 1'b0;
    logic parity_odd = 1'b0;

    int tick_div     = 0;
    int n_compared   = 0;
    int n_mismatched = 0;
    int done_idx     = -1;
    int scratch_idx  = -1;

    uart_rx_deframer_if #(.DBIT(8)) hold ();

    uart_rx_deframer #(
        .DBIT    (8),
        .OVS     (16),
        .SB_TICK (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_tick     (s_tick),
        .rx         (rx),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .hold       (hold.master)
    );

    always #5 clk = ~clk;

    // Baud generator stand-in: one s_tick every fourth clock, changed on the falling edge
    always @(negedge clk) begin
        tick_div = (tick_div == 3) ? 0 : tick_div + 1;
        s_tick   = (tick_div == 0);
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkStatus(input string tag, input logic [7:0] dout, input logic ready,
                               input logic perr, input logic ferr, input logic ovf);
        checkOutput({tag, "_dout"}, 32'(hold.dout), 32'(dout));
        checkOutput({tag, "_ready"}, 32'(hold.rx_ready), 32'(ready));
        checkOutput({tag, "_perr"}, 32'(hold.parity_err), 32'(perr));
        checkOutput({tag, "_ferr"}, 32'(hold.framing_err), 32'(ferr));
        checkOutput({tag, "_ovf"}, 32'(hold.overflow), 32'(ovf));
    endtask

    // Idle gap, then start/data/[parity]/stop; stop may be cut low for stop_low clocks,
    // rd_uart can be pulsed at stop-bit clock pop_at, and abort_at ends the frame mid-bit.
    // done_at reports the stop-bit clock on whose edge rx_ready rose from 0.
    task automatic applyStimulus(input logic [7:0] data, input bit with_par, input logic par_bit,
                                 input int stop_low, input int pop_at, input int abort_at,
                                 output int done_at);
        int   nb;
        logic ready_before;
        done_at = -1;
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        @(posedge clk iff s_tick);
        @(negedge clk);
        nb = with_par ? 10 : 9;
        for (int i = 0; i < nb; i++) begin
            if (i == 0)      rx = 1'b0;
            else if (i <= 8) rx = data[i-1];
            else             rx = par_bit;
            if (i == abort_at) begin
                repeat (BIT_CLKS / 2) @(negedge clk);
                return;
            end
            repeat (BIT_CLKS) @(negedge clk);
        end
        ready_before = hold.rx_ready;
        for (int j = 0; j < BIT_CLKS; j++) begin
            rx           = (j < stop_low) ? 1'b0 : 1'b1;
            hold.rd_uart = (j == pop_at);
            @(negedge clk);
            if (done_at < 0 && !ready_before && hold.rx_ready) done_at = j;
        end
        hold.rd_uart = 1'b0;
        rx           = 1'b1;
    endtask

    task automatic popByte();
        hold.rd_uart = 1'b1;
        @(negedge clk);
        hold.rd_uart = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        hold.rd_uart = 1'b0;
        repeat (4) @(negedge clk);
        checkStatus("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        $display("[TB] 8N1 0xA5");
        applyStimulus(8'hA5, 1'b0, 1'b0, 0, -1, -1, done_idx);
        checkStatus("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("a5_done_in_stop", 32'(done_idx >= 0), 32'd1);
        popByte();
        checkOutput("a5_pop_ready", 32'(hold.rx_ready), 32'd0);
        checkOutput("a5_pop_dout", 32'(hold.dout), 32'hA5);

        $display("[TB] 8E1 0x37 good and bad parity");
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        applyStimulus(8'h37, 1'b1, 1'b1, 0, -1, -1, scratch_idx);
        checkStatus("e37_good", 8'h37, 1'b1, 1'b0, 1'b0, 1'b0);
        popByte();
        applyStimulus(8'h37, 1'b1, 1'b0, 0, -1, -1, scratch_idx);
        checkStatus("e37_bad", 8'h37, 1'b1, 1'b1, 1'b0, 1'b0);
        popByte();

        $display("[TB] 8N1 0x55 with low stop bit, then 0x5A");
        parity_en = 1'b0;
        applyStimulus(8'h55, 1'b0, 1'b0, 44, -1, -1, scratch_idx);
        checkStatus("ferr55", 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        popByte();
        applyStimulus(8'h5A, 1'b0, 1'b0, 0, -1, -1, scratch_idx);
        checkStatus("after_ferr", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        popByte();

        $display("[TB] start glitch of 5 ticks");
        @(posedge clk iff s_tick);
        @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        checkStatus("glitch", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] overflow 0x11 then 0x22");
        applyStimulus(8'h11, 1'b0, 1'b0, 0, -1, -1, scratch_idx);
        applyStimulus(8'h22, 1'b0, 1'b0, 0, -1, -1, scratch_idx);
        checkStatus("ovf", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
        popByte();
        checkOutput("ovf_pop_ready", 32'(hold.rx_ready), 32'd0);
        checkOutput("ovf_pop_ovf", 32'(hold.overflow), 32'd0);
        applyStimulus(8'h11, 1'b0, 1'b0, 0, -1, -1, scratch_idx);
        checkStatus("pre_popdone", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h22, 1'b0, 1'b0, 0, done_idx, -1, scratch_idx);
        checkStatus("popdone", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        popByte();

        $display("[TB] reset during 0xF0, then 0x3C");
        applyStimulus(8'hF0, 1'b0, 1'b0, 0, -1, 5, scratch_idx);
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkStatus("midreset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h3C, 1'b0, 1'b0, 0, -1, -1, scratch_idx);
        checkStatus("after_reset", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
